// File: rtl/serial_pkg.sv
// Shared types and default framing constants for the serial receive link.
package serial_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } rx_state_t;

    localparam int unsigned SYNC_W_DEF    = 6;
    localparam logic [5:0]  SYNC_WORD_DEF = 6'b011010;
    localparam int unsigned DATA_W_DEF    = 8;

endpackage

// File: rtl/serial_sync_matcher.sv
// Sync-word hunter: shifts serial bits into a short history and flags a match
// when the history plus the current bit equals the sync pattern.
module serial_sync_matcher #(
    parameter int unsigned          SYNC_W    = 6,
    parameter logic [SYNC_W-1:0]    SYNC_WORD = 6'b011010
) (
    input  logic clk,
    input  logic rst,
    input  logic ser_bit,
    input  logic en,
    input  logic clr,
    output logic match_c
);

    localparam int unsigned HIST_W = SYNC_W - 1;

    logic [HIST_W-1:0] history;

    // Clearing wins over shifting so a new hunt never reuses stale bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history <= '0;
        end else if (clr) begin
            history <= '0;
        end else if (en) begin
            history <= {history[HIST_W-2:0], ser_bit};
        end
    end

    assign match_c = en && ({history, ser_bit} == SYNC_WORD);

endmodule

// File: rtl/serial_frame_controller.sv
// Serial frame receiver: sync hunt, MSB-first payload capture, even-parity check
// and a single-entry valid/ready output register with overflow flag.
module serial_frame_controller
    import serial_pkg::*;
#(
    parameter int unsigned       SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF),
    parameter int unsigned       DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serData,
    input  logic              enable,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              busy
);

    localparam int unsigned       CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    rx_state_t         state;
    rx_state_t         state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] payload;
    logic              match_c;
    logic              sync_clr_c;
    logic              good_word_c;
    logic              bad_word_c;
    logic              parity_ok_c;

    serial_sync_matcher #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .ser_bit (serData),
        .en      (state == HUNT),
        .clr     (sync_clr_c),
        .match_c (match_c)
    );

    assign parity_ok_c = ~(^{payload, serData});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus one-cycle strobes for frame completion and history clear.
    always_comb begin
        state_next  = state;
        sync_clr_c  = 1'b0;
        good_word_c = 1'b0;
        bad_word_c  = 1'b0;
        if (!enable) begin
            state_next = HUNT;
            sync_clr_c = 1'b1;
        end else begin
            case (state)
                HUNT: begin
                    if (match_c) begin
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (bit_cnt == LAST_CNT) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    state_next = HUNT;
                    sync_clr_c = 1'b1;
                    if (parity_ok_c) begin
                        good_word_c = 1'b1;
                    end else begin
                        bad_word_c = 1'b1;
                    end
                end
                default: begin
                    state_next = HUNT;
                    sync_clr_c = 1'b1;
                end
            endcase
        end
    end

    // Counter is held at zero in HUNT so every payload starts from bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            payload <= '0;
        end else begin
            if (state == PAYLOAD) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                payload <= {payload[DATA_W-2:0], serData};
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    // Output register: a same-cycle transfer frees the slot for the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= bad_word_c;
            if (good_word_c && (!data_valid || data_ready)) begin
                data_out   <= payload;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (good_word_c && data_valid && !data_ready) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy = (state != HUNT);

endmodule
